turn_scheduler: RTL and testbench
=================================

TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25000000: turn time limit in clk cycles, minimum 2.
REQ-002 SHALL have parameter MAX_MISSES, default 3: misses that end the game, range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock for all state; the pixel clock domain.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a game.
REQ-006 SHALL have port correct_note, input, 1: one-cycle pulse from the MIDI memory manager when the played note matches.
REQ-007 SHALL have port p1_miss, input, 1: one-cycle pulse from the VGA block when the ball passes player 1.
REQ-008 SHALL have port p2_miss, input, 1: one-cycle pulse from the VGA block when the ball passes player 2.
REQ-009 SHALL have port note_en, output, 1: one-cycle pulse that arms target-note compare in the memory manager.
REQ-010 SHALL have port timer_on, output, 1: high while a turn is being timed.
REQ-011 SHALL have ports p1turn and p2turn, output, 1 each: active player; the two are never high together.
REQ-012 SHALL have port score, output, 5: rally hit count, sent to the LED driver.
REQ-013 SHALL have port misses, output, 4: misses accumulated in the current game.
REQ-014 SHALL have port game_over, output, 1: high in state OVER.

Function
REQ-015 SHALL register all outputs; no combinational input-to-output path.
REQ-016 SHALL implement FSM states IDLE, SERVE, WAIT, HIT, MISS, OVER.
REQ-017 IDLE: all outputs low; start -> SERVE with player 1 active; score and misses cleared.
REQ-018 SERVE: note_en high for exactly this one cycle; timer loaded with TIMEOUT_CYCLES-1; next state WAIT.
REQ-019 WAIT: timer_on high; timer decrements once per cycle; start is ignored.
REQ-020 WAIT on correct_note -> HIT.
REQ-021 WAIT on miss pulse of the active player, or timer==0 -> MISS.
REQ-022 WAIT: the miss pulse of the inactive player is ignored.
REQ-023 WAIT: correct_note together with a miss pulse, or with timer==0, in the same cycle -> HIT (correct wins).
REQ-024 HIT: score +1, saturating at 31; active player toggles; next state SERVE.
REQ-025 MISS: misses +1; if the new value equals MAX_MISSES -> OVER, else SERVE with the other player active.
REQ-026 OVER: game_over high; p1turn, p2turn and timer_on low; score and misses held; start -> SERVE with score and misses cleared and player 1 active.
REQ-027 Latency: start sampled at cycle N gives note_en at N+1 and timer_on at N+2; correct_note at cycle M gives the score update visible at M+2.
REQ-028 Turn outputs SHALL change only on the SERVE entry edge; they are stable for the whole of WAIT.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, timer=0, score=0, misses=0 and all outputs low, including when reset is asserted mid-WAIT.
REQ-030 Release of reset SHALL be treated synchronously; the first state evaluation happens on the first clk edge with reset high.

Configuration
REQ-031 Macro TURN_SCHED_TIMEOUT_EN defined: timer counter is built, and timer==0 in WAIT counts as a miss.
REQ-032 Macro TURN_SCHED_TIMEOUT_EN undefined: no counter logic; WAIT leaves only on correct_note or an active-player miss; timer_on still follows WAIT.

Verification
REQ-033 reset low mid-WAIT with score=7 -> same cycle: score=0, p1turn=0, timer_on=0, state IDLE.
REQ-034 start, then correct_note 5 cycles after note_en -> score=1, p2turn=1, second note_en pulse 2 cycles after correct_note.
REQ-035 In WAIT with p1 active: p2_miss pulse -> no state change; p1_miss pulse -> misses=1, p2turn=1.
REQ-036 TIMEOUT_CYCLES=4, TURN_SCHED_TIMEOUT_EN defined, no input -> MISS 4 cycles after entering WAIT; with MAX_MISSES=1, game_over=1.
REQ-037 correct_note and p1_miss in the same WAIT cycle -> score +1, misses unchanged.
REQ-038 32 consecutive hits -> score saturates at 31; start in OVER -> score=0, misses=0, p1turn=1.

Source files
------------

// File: rtl/turn_scheduler.sv
// Two-player note-rally turn scheduler: serves turns, scores hits, counts misses, ends the game.
// Defining TURN_SCHED_TIMEOUT_EN builds the turn timer so an expired turn counts as a miss.
module turn_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 25000000,
    parameter int unsigned MAX_MISSES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       correct_note,
    input  logic       p1_miss,
    input  logic       p2_miss,
    output logic       note_en,
    output logic       timer_on,
    output logic       p1turn,
    output logic       p2turn,
    output logic [4:0] score,
    output logic [3:0] misses,
    output logic       game_over
);

    localparam int unsigned SCORE_W = 5;
    localparam int unsigned MISS_W  = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

    // Elaboration-time guard on parameter ranges.
    generate
        if (TIMEOUT_CYCLES < 2 || MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_bad_param
            $error("turn_scheduler: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_WAIT,
        S_HIT,
        S_MISS,
        S_OVER
    } state_t;

    state_t              r_state;
    logic                r_note_en;
    logic                r_timer_on;
    logic                r_p1turn;
    logic                r_p2turn;
    logic [SCORE_W-1:0]  r_score;
    logic [MISS_W-1:0]   r_misses;
    logic                r_game_over;

    logic                w_active_miss;
    logic                w_timeout;
    logic [MISS_W-1:0]   w_misses_inc;

    assign w_active_miss = (r_p1turn & p1_miss) | (r_p2turn & p2_miss);
    assign w_misses_inc  = r_misses + MISS_W'(1);

`ifdef TURN_SCHED_TIMEOUT_EN
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] r_timer;

    assign w_timeout = (r_timer == '0);

    // Loaded while serving so WAIT lasts exactly TIMEOUT_CYCLES cycles before timing out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_state == S_SERVE) begin
            r_timer <= TIMER_LOAD;
        end else if (r_state == S_WAIT && r_timer != '0) begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Game FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_note_en   <= 1'b0;
            r_timer_on  <= 1'b0;
            r_p1turn    <= 1'b0;
            r_p2turn    <= 1'b0;
            r_score     <= '0;
            r_misses    <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_note_en <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state     <= S_SERVE;
                        r_note_en   <= 1'b1;
                        r_p1turn    <= 1'b1;
                        r_p2turn    <= 1'b0;
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_game_over <= 1'b0;
                    end
                end
                S_SERVE: begin
                    r_state    <= S_WAIT;
                    r_timer_on <= 1'b1;
                end
                S_WAIT: begin
                    // A correct note wins over a simultaneous miss or timeout.
                    if (correct_note) begin
                        r_state    <= S_HIT;
                        r_timer_on <= 1'b0;
                    end else if (w_active_miss || w_timeout) begin
                        r_state    <= S_MISS;
                        r_timer_on <= 1'b0;
                    end
                end
                S_HIT: begin
                    r_state   <= S_SERVE;
                    r_note_en <= 1'b1;
                    r_p1turn  <= r_p2turn;
                    r_p2turn  <= r_p1turn;
                    if (r_score != SCORE_MAX) begin
                        r_score <= r_score + SCORE_W'(1);
                    end
                end
                S_MISS: begin
                    r_misses <= w_misses_inc;
                    if (w_misses_inc == MISS_LIMIT) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                        r_p1turn    <= 1'b0;
                        r_p2turn    <= 1'b0;
                    end else begin
                        r_state   <= S_SERVE;
                        r_note_en <= 1'b1;
                        r_p1turn  <= r_p2turn;
                        r_p2turn  <= r_p1turn;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign note_en   = r_note_en;
    assign timer_on  = r_timer_on;
    assign p1turn    = r_p1turn;
    assign p2turn    = r_p2turn;
    assign score     = r_score;
    assign misses    = r_misses;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: game-level model checked every cycle plus directed literal checks.
// Honours TURN_SCHED_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_turn_scheduler;

    localparam int TO_A   = 16;
    localparam int MAXM_A = 3;

`ifdef TURN_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, correct_note, p1_miss, p2_miss;
    logic       note_en, timer_on, p1turn, p2turn, game_over;
    logic [4:0] score;
    logic [3:0] misses;

    logic       b_start;
    logic       b_note_en, b_timer_on, b_p1turn, b_p2turn, b_game_over;
    logic [4:0] b_score;
    logic [3:0] b_misses;

    int n_checks = 0;
    int n_errors = 0;

    turn_scheduler #(.TIMEOUT_CYCLES(TO_A), .MAX_MISSES(MAXM_A)) dut (
        .clk(clk), .reset(reset), .start(start), .correct_note(correct_note),
        .p1_miss(p1_miss), .p2_miss(p2_miss), .note_en(note_en), .timer_on(timer_on),
        .p1turn(p1turn), .p2turn(p2turn), .score(score), .misses(misses),
        .game_over(game_over)
    );

    turn_scheduler #(.TIMEOUT_CYCLES(4), .MAX_MISSES(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .correct_note(1'b0),
        .p1_miss(1'b0), .p2_miss(1'b0), .note_en(b_note_en), .timer_on(b_timer_on),
        .p1turn(b_p1turn), .p2turn(b_p2turn), .score(b_score), .misses(b_misses),
        .game_over(b_game_over)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: phase of play, whose turn, score, misses, cycles spent waiting.
    typedef enum int {P_IDLE, P_SERVE, P_WAIT, P_HIT, P_MISS, P_OVER} phase_t;
    phase_t m_phase;
    int     m_player, m_score, m_misses, m_age;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase  <= P_IDLE;
            m_player <= 1;
            m_score  <= 0;
            m_misses <= 0;
            m_age    <= 0;
        end else begin
            case (m_phase)
                P_IDLE, P_OVER: if (start) begin
                    m_phase  <= P_SERVE;
                    m_player <= 1;
                    m_score  <= 0;
                    m_misses <= 0;
                end
                P_SERVE: begin
                    m_phase <= P_WAIT;
                    m_age   <= 0;
                end
                P_WAIT: begin
                    if (correct_note)
                        m_phase <= P_HIT;
                    else if ((m_player == 1 && p1_miss) || (m_player == 2 && p2_miss) ||
                             (TIMEOUT_EN && m_age == TO_A - 1))
                        m_phase <= P_MISS;
                    m_age <= m_age + 1;
                end
                P_HIT: begin
                    m_phase  <= P_SERVE;
                    m_score  <= (m_score >= 31) ? 31 : m_score + 1;
                    m_player <= 3 - m_player;
                end
                P_MISS: begin
                    m_misses <= m_misses + 1;
                    if (m_misses + 1 == MAXM_A) begin
                        m_phase <= P_OVER;
                    end else begin
                        m_phase  <= P_SERVE;
                        m_player <= 3 - m_player;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        automatic bit in_play = (m_phase == P_SERVE || m_phase == P_WAIT ||
                                 m_phase == P_HIT || m_phase == P_MISS);
        check("note_en",   note_en,   int'(m_phase == P_SERVE));
        check("timer_on",  timer_on,  int'(m_phase == P_WAIT));
        check("p1turn",    p1turn,    int'(in_play && m_player == 1));
        check("p2turn",    p2turn,    int'(in_play && m_player == 2));
        check("score",     score,     m_score);
        check("misses",    misses,    m_misses);
        check("game_over", game_over, int'(m_phase == P_OVER));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From SERVE: the active player hits on the first WAIT cycle; ends in the next SERVE.
    task automatic do_hit();
        tick();
        correct_note = 1'b1;
        tick();
        correct_note = 1'b0;
        tick();
    endtask

    // From SERVE: the active player misses on the first WAIT cycle.
    task automatic do_miss();
        tick();
        if (m_player == 1) p1_miss = 1'b1;
        else               p2_miss = 1'b1;
        tick();
        p1_miss = 1'b0;
        p2_miss = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; correct_note = 1'b0; p1_miss = 1'b0; p2_miss = 1'b0;
        b_start = 1'b0;
        repeat (2) tick();
        check("rst_score",   score, 0);
        check("rst_p1turn",  p1turn, 0);
        check("rst_b_timer", b_timer_on, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Short-timeout instance, single-miss game.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_note_en", b_note_en, 1);
        tick();
        check("b_timer_on_first", b_timer_on, 1);
        repeat (3) tick();
`ifdef TURN_SCHED_TIMEOUT_EN
        check("b_timer_on_last", b_timer_on, 1);
        tick();
        check("b_timer_off_miss", b_timer_on, 0);
        check("b_not_over_yet", b_game_over, 0);
        tick();
        check("b_game_over", b_game_over, 1);
        check("b_misses", b_misses, 1);
        check("b_p1turn_over", b_p1turn, 0);
`else
        repeat (15) tick();
        check("b_timer_stays_on", b_timer_on, 1);
        check("b_no_game_over", b_game_over, 0);
`endif

        // Start, then correct note 5 cycles after note_en.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("serve_note_en", note_en, 1);
        check("serve_p1turn", p1turn, 1);
        repeat (5) tick();
        correct_note = 1'b1;
        tick();
        correct_note = 1'b0;
        check("hit_score_not_yet", score, 0);
        tick();
        check("hit_score", score, 1);
        check("hit_p2turn", p2turn, 1);
        check("hit_note_en2", note_en, 1);

        do_hit();
        check("score_after_p2_hit", score, 2);
        check("p1_back", p1turn, 1);

        // Inactive-player miss and start in WAIT are ignored; active miss counts.
        tick();
        p2_miss = 1'b1;
        tick();
        p2_miss = 1'b0;
        check("ignore_p2miss_timer", timer_on, 1);
        check("ignore_p2miss_misses", misses, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_start_timer", timer_on, 1);
        p1_miss = 1'b1;
        tick();
        p1_miss = 1'b0;
        tick();
        check("p1miss_misses", misses, 1);
        check("p1miss_p2turn", p2turn, 1);
        check("p1miss_score", score, 2);

        do_hit();
        // Correct note and active miss together: the hit wins.
        tick();
        correct_note = 1'b1;
        p1_miss = 1'b1;
        tick();
        correct_note = 1'b0;
        p1_miss = 1'b0;
        tick();
        check("tie_score", score, 4);
        check("tie_misses", misses, 1);
        check("tie_p2turn", p2turn, 1);

        repeat (3) do_hit();
        tick();
        check("pre_rst_score", score, 7);
        check("pre_rst_p1turn", p1turn, 1);
        // Asynchronous reset in the middle of WAIT.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_score", score, 0);
        check("async_rst_p1turn", p1turn, 0);
        check("async_rst_timer_on", timer_on, 0);
        check("async_rst_misses", misses, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Idle turn: model decides whether the timer fires.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Saturation and game over, then restart from OVER.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) do_hit();
        check("sat_score", score, 31);
        check("sat_p1turn", p1turn, 1);
        repeat (3) do_miss();
        check("over_game_over", game_over, 1);
        check("over_score_held", score, 31);
        check("over_misses", misses, 3);
        check("over_p1turn", p1turn, 0);
        check("over_timer_on", timer_on, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);
        check("restart_p1turn", p1turn, 1);
        check("restart_game_over", game_over, 0);
        check("restart_note_en", note_en, 1);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
